id_ctrl_pipe: RTL and testbench

ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

---
 rtl/id_ctrl_pipe_pkg.sv | 81 ++++++++
 rtl/id_ctrl_pipe_ctrl_dec.sv | 106 ++++++++++
 rtl/id_ctrl_pipe.sv | 125 ++++++++++++
 tb/tb_id_ctrl_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pipe_pkg.sv
// Shared decode definitions for the ID stage: ALU op codes, pc/writeback selects,
// immediate formats, opcodes and the decoded control bundle.
package id_ctrl_pipe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
        ALU_SLTU   = 5'd4,  ALU_XOR   = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
        ALU_OR     = 5'd8,  ALU_AND   = 5'd9,  ALU_EQ   = 5'd10, ALU_NE   = 5'd11,
        ALU_LT     = 5'd12, ALU_GE    = 5'd13, ALU_LTU  = 5'd14, ALU_GEU  = 5'd15,
        ALU_MUL    = 5'd16, ALU_MULH  = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
        ALU_DIV    = 5'd20, ALU_DIVU  = 5'd21, ALU_REM  = 5'd22, ALU_REMU = 5'd23
    } alu_op_e;

    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;
    localparam logic [1:0] PC_SEL_JALR   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef enum logic {ST_RUN, ST_LU_STALL} stall_state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    typedef struct packed {
        alu_op_e     alu_ctrl;
        logic [1:0]  pc_sel;
        logic [1:0]  reg_write;
        logic        reg_we;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        op_a_sel;
        logic        op_b_sel;
        logic [2:0]  mem_size;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } ctrl_t;

    // funct3 -> ALU op for the register/immediate arithmetic group (funct7 = 0)
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   gen_imm = {i[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: gen_imm = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ctrl_pipe_ctrl_dec.sv
// Combinational RV32I(+M) decoder: raw instruction word -> control bundle and
// sign-extended immediate. Illegal encodings produce an all-zero bundle with illegal set.
module ctrl_dec
    import id_ctrl_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]     inst,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    imm_fmt_e   fmt;
    logic       ill;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        ctrl = '0;
        fmt  = IMM_NONE;
        ill  = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                fmt = IMM_U; ctrl.rd = inst[11:7]; ctrl.reg_we = 1'b1; ctrl.reg_write = WB_IMM;
            end
            OPC_AUIPC: begin
                fmt = IMM_U; ctrl.rd = inst[11:7]; ctrl.reg_we = 1'b1; ctrl.op_a_sel = 1'b1;
            end
            OPC_JAL: begin
                fmt = IMM_J; ctrl.rd = inst[11:7]; ctrl.reg_we = 1'b1; ctrl.op_a_sel = 1'b1;
                ctrl.reg_write = WB_PC4; ctrl.pc_sel = PC_SEL_JAL;
            end
            OPC_JALR: begin
                fmt = IMM_I; ctrl.rs1 = inst[19:15]; ctrl.rd = inst[11:7]; ctrl.reg_we = 1'b1;
                ctrl.reg_write = WB_PC4; ctrl.pc_sel = PC_SEL_JALR;
                ill = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                // op_b is the register operand: EX compares rs1/rs2, NPC adds pc+imm
                fmt = IMM_B; ctrl.rs1 = inst[19:15]; ctrl.rs2 = inst[24:20];
                ctrl.branch = 1'b1; ctrl.pc_sel = PC_SEL_BRANCH; ctrl.op_b_sel = 1'b1;
                case (funct3)
                    3'b000:  ctrl.alu_ctrl = ALU_EQ;
                    3'b001:  ctrl.alu_ctrl = ALU_NE;
                    3'b100:  ctrl.alu_ctrl = ALU_LT;
                    3'b101:  ctrl.alu_ctrl = ALU_GE;
                    3'b110:  ctrl.alu_ctrl = ALU_LTU;
                    3'b111:  ctrl.alu_ctrl = ALU_GEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt = IMM_I; ctrl.rs1 = inst[19:15]; ctrl.rd = inst[11:7]; ctrl.reg_we = 1'b1;
                ctrl.mem_read = 1'b1; ctrl.reg_write = WB_MEM; ctrl.mem_size = funct3;
                ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                fmt = IMM_S; ctrl.rs1 = inst[19:15]; ctrl.rs2 = inst[24:20];
                ctrl.mem_write = 1'b1; ctrl.mem_size = funct3;
                ill = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; ctrl.rs1 = inst[19:15]; ctrl.rd = inst[11:7]; ctrl.reg_we = 1'b1;
                ctrl.alu_ctrl = base_alu(funct3);
                if (funct3 == 3'b001) begin
                    ill = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)
                        ctrl.alu_ctrl = ALU_SRA;
                    else
                        ill = (funct7 != 7'b0000000);
                end
            end
            OPC_OP: begin
                ctrl.rs1 = inst[19:15]; ctrl.rs2 = inst[24:20]; ctrl.rd = inst[11:7];
                ctrl.reg_we = 1'b1; ctrl.op_b_sel = 1'b1;
                if (funct7 == 7'b0000000)
                    ctrl.alu_ctrl = base_alu(funct3);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000)
                    ctrl.alu_ctrl = ALU_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101)
                    ctrl.alu_ctrl = ALU_SRA;
                else if (funct7 == 7'b0000001 && ENABLE_M)
                    ctrl.alu_ctrl = alu_op_e'({2'b10, funct3});
                else
                    ill = 1'b1;
            end
            OPC_MISC_MEM: ill = (funct3 != 3'b000);
            default:      ill = 1'b1;
        endcase
        if (ill) begin
            ctrl = '0;
            fmt  = IMM_NONE;
        end
        ctrl.illegal = ill;
    end

    assign imm = XLEN'($signed(gen_imm(inst, fmt)));

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID stage: decodes the fetched instruction into the ID/EX register, inserts
// load-use bubbles, honours EX back-pressure and redirect flushes.
module id_ctrl_pipe
    import id_ctrl_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            if_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            ex_ready,
    input  logic            redirect,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_alu_ctrl,
    output logic [1:0]      ex_pc_sel,
    output logic [1:0]      ex_reg_write,
    output logic            ex_reg_we,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_op_a_sel,
    output logic            ex_op_b_sel,
    output logic [2:0]      ex_mem_size,
    output logic            ex_illegal,
    output logic [15:0]     stall_cnt
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    ctrl_t           ctrl_q, ctrl_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
    stall_state_e    state_q, state_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            hazard;

    ctrl_dec #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_dec (
        .inst (inst),
        .ctrl (dec_ctrl),
        .imm  (dec_imm)
    );

    // Unused source fields decode to x0, so the rd != 0 term rules them out.
    assign hazard = if_valid & valid_q & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) &
                    ((ctrl_q.rd == dec_ctrl.rs1) | (ctrl_q.rd == dec_ctrl.rs2));

    assign id_ready = redirect | (ex_ready & ~hazard);

    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (ex_ready) begin
            // Default is a fully zeroed bubble; only a clean accept loads the decoder
            valid_d = 1'b0;
            ctrl_d  = '0;
            pc_d    = '0;
            imm_d   = '0;
            state_d = ST_RUN;
            if (!redirect && hazard) begin
                state_d = ST_LU_STALL;
            end else if (!redirect && if_valid) begin
                valid_d = 1'b1;
                ctrl_d  = dec_ctrl;
                pc_d    = if_pc;
                imm_d   = dec_imm;
            end
        end
        if (redirect)
            state_d = ST_RUN;
        if (state_q == ST_RUN && state_d == ST_LU_STALL && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = ctrl_q.rs1;
    assign ex_rs2       = ctrl_q.rs2;
    assign ex_rd        = ctrl_q.rd;
    assign ex_alu_ctrl  = ctrl_q.alu_ctrl;
    assign ex_pc_sel    = ctrl_q.pc_sel;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_reg_we    = ctrl_q.reg_we;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_branch    = ctrl_q.branch;
    assign ex_op_a_sel  = ctrl_q.op_a_sel;
    assign ex_op_b_sel  = ctrl_q.op_b_sel;
    assign ex_mem_size  = ctrl_q.mem_size;
    assign ex_illegal   = ctrl_q.illegal;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: decode vector table plus hand-written
// load-use, back-pressure, redirect and reset sequences.
module tb_id_ctrl_pipe;

    typedef logic [98:0] bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic        ill;
        logic [4:0]  alu;
        logic [1:0]  pcs;
        logic [1:0]  rw;
        logic        we, mr, mw, br, a, b;
        logic [2:0]  msz;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } vec_t;

    logic        clk, rst, if_valid, ex_ready, redirect;
    logic [31:0] inst, if_pc;

    logic        id_ready, ex_valid, ex_reg_we, ex_mem_read, ex_mem_write, ex_branch;
    logic        ex_op_a_sel, ex_op_b_sel, ex_illegal;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl;
    logic [1:0]  ex_pc_sel, ex_reg_write;
    logic [2:0]  ex_mem_size;
    logic [15:0] stall_cnt;

    logic        m_id_ready, m_ex_valid, m_ex_reg_we, m_ex_mem_read, m_ex_mem_write, m_ex_branch;
    logic        m_ex_op_a_sel, m_ex_op_b_sel, m_ex_illegal;
    logic [31:0] m_ex_pc, m_ex_imm;
    logic [4:0]  m_ex_rs1, m_ex_rs2, m_ex_rd, m_ex_alu_ctrl;
    logic [1:0]  m_ex_pc_sel, m_ex_reg_write;
    logic [2:0]  m_ex_mem_size;
    logic [15:0] m_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b0)) dut (
        .cpu_clk(clk), .cpu_rst(rst), .if_valid(if_valid), .inst(inst), .if_pc(if_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .redirect(redirect), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_pc_sel(ex_pc_sel), .ex_reg_write(ex_reg_write),
        .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_op_a_sel(ex_op_a_sel), .ex_op_b_sel(ex_op_b_sel),
        .ex_mem_size(ex_mem_size), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    id_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b1)) dut_m (
        .cpu_clk(clk), .cpu_rst(rst), .if_valid(if_valid), .inst(inst), .if_pc(if_pc),
        .id_ready(m_id_ready), .ex_ready(ex_ready), .redirect(redirect), .ex_valid(m_ex_valid),
        .ex_pc(m_ex_pc), .ex_imm(m_ex_imm), .ex_rs1(m_ex_rs1), .ex_rs2(m_ex_rs2), .ex_rd(m_ex_rd),
        .ex_alu_ctrl(m_ex_alu_ctrl), .ex_pc_sel(m_ex_pc_sel), .ex_reg_write(m_ex_reg_write),
        .ex_reg_we(m_ex_reg_we), .ex_mem_read(m_ex_mem_read), .ex_mem_write(m_ex_mem_write),
        .ex_branch(m_ex_branch), .ex_op_a_sel(m_ex_op_a_sel), .ex_op_b_sel(m_ex_op_b_sel),
        .ex_mem_size(m_ex_mem_size), .ex_illegal(m_ex_illegal), .stall_cnt(m_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bundle_t obs0();
        return {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_pc_sel,
                ex_reg_write, ex_reg_we, ex_mem_read, ex_mem_write, ex_branch,
                ex_op_a_sel, ex_op_b_sel, ex_mem_size, ex_illegal};
    endfunction

    function automatic bundle_t obs1();
        return {m_ex_valid, m_ex_pc, m_ex_imm, m_ex_rs1, m_ex_rs2, m_ex_rd, m_ex_alu_ctrl,
                m_ex_pc_sel, m_ex_reg_write, m_ex_reg_we, m_ex_mem_read, m_ex_mem_write,
                m_ex_branch, m_ex_op_a_sel, m_ex_op_b_sel, m_ex_mem_size, m_ex_illegal};
    endfunction

    function automatic bundle_t expv(input logic v, input logic [31:0] pc, input vec_t e);
        return {v, pc, e.imm, e.rs1, e.rs2, e.rd, e.alu, e.pcs, e.rw, e.we, e.mr, e.mw,
                e.br, e.a, e.b, e.msz, e.ill};
    endfunction

    task automatic check(input string nm, input bundle_t act, input bundle_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[19];
    vec_t v_add3, v_sub, v_lw, v_add6, v_mul_m;

    initial begin
        vecs[0]  = '{32'h002081B3, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 2, 3, 0};
        vecs[1]  = '{32'h407302B3, 0, 1,  0, 0, 1, 0, 0, 0, 0, 1, 0, 6, 7, 5, 0};
        vecs[2]  = '{32'hFFF00093, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF};
        vecs[3]  = '{32'h4051D113, 0, 7,  0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 2, 32'h405};
        vecs[4]  = '{32'h0051D113, 0, 6,  0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 2, 32'h5};
        vecs[5]  = '{32'h02111093, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{32'h7FF2B213, 0, 4,  0, 0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 4, 32'h7FF};
        vecs[7]  = '{32'h12345537, 0, 0,  0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 10, 32'h12345000};
        vecs[8]  = '{32'hFFFFF597, 0, 0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 11, 32'hFFFFF000};
        vecs[9]  = '{32'hFFDFF0EF, 0, 0,  2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hFFFFFFFC};
        vecs[10] = '{32'h00008067, 0, 0,  3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{32'h0020E463, 0, 14, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 0, 32'h8};
        vecs[12] = '{32'hFE41F8E3, 0, 15, 1, 0, 0, 0, 0, 1, 0, 1, 0, 3, 4, 0, 32'hFFFFFFF0};
        vecs[13] = '{32'h0020A463, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{32'hFFF14383, 0, 0,  0, 2, 1, 1, 0, 0, 0, 0, 4, 2, 0, 7, 32'hFFFFFFFF};
        vecs[15] = '{32'h00531323, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 6, 5, 0, 32'h6};
        vecs[16] = '{32'h023100B3, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[17] = '{32'hFFFFFFFF, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{32'h00A4A433, 0, 3,  0, 0, 1, 0, 0, 0, 0, 1, 0, 9, 10, 8, 0};
        v_add3  = vecs[0];
        v_sub   = vecs[1];
        v_lw    = '{32'h0000A283, 0, 0,  0, 2, 1, 1, 0, 0, 0, 0, 2, 1, 0, 5, 0};
        v_add6  = '{32'h00528333, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0, 5, 5, 6, 0};
        v_mul_m = '{32'h023100B3, 0, 16, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 3, 1, 0};

        rst = 1'b1; if_valid = 1'b0; inst = 32'h0; if_pc = 32'h0; ex_ready = 1'b1; redirect = 1'b0;
        #3;
        check("reset_outputs", obs0(), bundle_t'(0));
        check("reset_stall_cnt", bundle_t'(stall_cnt), bundle_t'(0));
        tick();
        rst = 1'b0;

        // Decode table: one accept per vector, then an idle cycle
        for (int i = 0; i < 19; i++) begin
            inst = vecs[i].inst; if_pc = 32'h1000 + 32'(i) * 4; if_valid = 1'b1;
            tick();
            check($sformatf("vec%0d_decode", i), obs0(), expv(1'b1, 32'h1000 + 32'(i) * 4, vecs[i]));
            $display("vec %0d inst=%h pc=%h ex_valid=%b alu=%0d illegal=%b",
                     i, vecs[i].inst, ex_pc, ex_valid, ex_alu_ctrl, ex_illegal);
            if_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_idle_valid", i), bundle_t'(ex_valid), bundle_t'(0));
        end

        // mul decodes legally only with the M extension enabled
        inst = v_mul_m.inst; if_pc = 32'h1800; if_valid = 1'b1;
        tick();
        check("mul_m1_decode", obs1(), expv(1'b1, 32'h1800, v_mul_m));
        check("mul_m0_illegal_we", bundle_t'({ex_illegal, ex_reg_we}), bundle_t'(2'b10));
        $display("mul m0: illegal=%b we=%b  m1: illegal=%b alu=%0d", ex_illegal, ex_reg_we,
                 m_ex_illegal, m_ex_alu_ctrl);

        // Load-use: lw x5 then add x6,x5,x5
        inst = v_lw.inst; if_pc = 32'h2000;
        tick();
        check("lu_lw_loaded", obs0(), expv(1'b1, 32'h2000, v_lw));
        inst = v_add6.inst; if_pc = 32'h2004;
        #1;
        check("lu_id_ready_low", bundle_t'(id_ready), bundle_t'(0));
        tick();
        check("lu_bubble", obs0(), bundle_t'(0));
        check("lu_stall_cnt", bundle_t'(stall_cnt), bundle_t'(1));
        check("lu_id_ready_back", bundle_t'(id_ready), bundle_t'(1));
        tick();
        check("lu_add_after_bubble", obs0(), expv(1'b1, 32'h2004, v_add6));
        $display("load-use: add at pc=%h stall_cnt=%0d", ex_pc, stall_cnt);

        // A load to x0 never stalls a consumer of x0
        inst = 32'h0000A003; if_pc = 32'h2100;
        tick();
        inst = 32'h00000333; if_pc = 32'h2104;
        #1;
        check("x0_no_hazard_ready", bundle_t'(id_ready), bundle_t'(1));
        tick();
        check("x0_no_hazard_loaded", bundle_t'({ex_valid, ex_rd, ex_pc}), bundle_t'({1'b1, 5'd6, 32'h2104}));
        check("x0_stall_cnt", bundle_t'(stall_cnt), bundle_t'(1));

        // EX back-pressure for three cycles holds everything
        inst = v_add3.inst; if_pc = 32'h3000;
        tick();
        ex_ready = 1'b0; inst = v_sub.inst; if_pc = 32'h3004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d_id_ready", k), bundle_t'(id_ready), bundle_t'(0));
            tick();
            check($sformatf("hold%0d_outputs", k), obs0(), expv(1'b1, 32'h3000, v_add3));
            check($sformatf("hold%0d_stall_cnt", k), bundle_t'(stall_cnt), bundle_t'(1));
            $display("hold cycle %0d: ex_pc=%h ex_valid=%b", k, ex_pc, ex_valid);
        end
        ex_ready = 1'b1;
        tick();
        check("hold_release_sub", obs0(), expv(1'b1, 32'h3004, v_sub));

        // Redirect drops the fetched instruction
        inst = v_add3.inst; if_pc = 32'h4000; redirect = 1'b1;
        #1;
        check("redir_id_ready", bundle_t'(id_ready), bundle_t'(1));
        tick();
        check("redir_flush", obs0(), bundle_t'(0));
        redirect = 1'b0;

        // Redirect over a load-use hazard: flush, no stall counted
        inst = v_lw.inst; if_pc = 32'h4010;
        tick();
        inst = v_add6.inst; if_pc = 32'h4014; redirect = 1'b1;
        #1;
        check("redir_hz_id_ready", bundle_t'(id_ready), bundle_t'(1));
        tick();
        check("redir_hz_flush", obs0(), bundle_t'(0));
        check("redir_hz_stall_cnt", bundle_t'(stall_cnt), bundle_t'(1));
        redirect = 1'b0;
        tick();
        check("redir_hz_add_loaded", obs0(), expv(1'b1, 32'h4014, v_add6));
        $display("redirect: flushed, then add at pc=%h", ex_pc);

        // Asynchronous reset mid-stream with a valid instruction held
        #2; rst = 1'b1;
        #1;
        check("async_rst_outputs", obs0(), bundle_t'(0));
        check("async_rst_stall_cnt", bundle_t'(stall_cnt), bundle_t'(0));
        rst = 1'b0;
        inst = v_lw.inst; if_pc = 32'h5000;
        tick();
        inst = v_add6.inst; if_pc = 32'h5004;
        tick();
        check("stall2_bubble", obs0(), bundle_t'(0));
        check("stall2_cnt", bundle_t'(stall_cnt), bundle_t'(1));

        // Reset during the stall discards it; the pending add then decodes normally
        #2; rst = 1'b1;
        #1;
        check("stall_rst_outputs", obs0(), bundle_t'(0));
        check("stall_rst_cnt", bundle_t'(stall_cnt), bundle_t'(0));
        rst = 1'b0;
        tick();
        check("post_rst_add", obs0(), expv(1'b1, 32'h5004, v_add6));
        inst = v_lw.inst; if_pc = 32'h5008;
        tick();
        inst = v_add6.inst; if_pc = 32'h500C;
        tick();
        check("post_rst_stall_cnt", bundle_t'(stall_cnt), bundle_t'(1));
        tick();
        check("post_rst_add2", obs0(), expv(1'b1, 32'h500C, v_add6));
        $display("reset sequences: stall_cnt=%0d ex_pc=%h", stall_cnt, ex_pc);
        if_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
